// File: rtl/fifo64_fwft.sv
// 64+1 entry first-word-fall-through FIFO over a 64-deep distributed SDP RAM.
// Optional registered almost_full/almost_empty flags are enabled with FIFO64_ALMOST_EN.

module ram64xsdp #(
    parameter int WIDTH = 16
) (
    input  logic             wclk,
    input  logic             we,
    input  logic [5:0]       waddr,
    input  logic [WIDTH-1:0] datai,
    input  logic [5:0]       raddr,
    output logic [WIDTH-1:0] datao
);
    logic [WIDTH-1:0] mem [64];

    // NOTE: storage is deliberately left without reset; the FIFO pointers decide which entries are valid.
    always_ff @(posedge wclk) begin
        if (we) mem[waddr] <= datai;
    end

    assign datao = mem[raddr];
endmodule

module fifo64_fwft #(
    parameter int WIDTH         = 16,
    parameter int AFULL_THRESH  = 48,
    parameter int AEMPTY_THRESH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [6:0]       level
`ifdef FIFO64_ALMOST_EN
    ,
    output logic             almost_full,
    output logic             almost_empty
`endif
);
    if (AFULL_THRESH > 65 || AEMPTY_THRESH > 65) begin : g_thresh_range
        $error("fifo64_fwft: almost thresholds must not exceed 65");
    end

    logic [6:0]       wptr, rptr;
    logic [6:0]       wptr_nxt, rptr_nxt;
    logic [6:0]       ram_cnt;
    logic [6:0]       level_nxt;
    logic             out_valid_nxt;
    logic             ram_full, ram_empty;
    logic             run;
    logic             wr, load;
    logic [WIDTH-1:0] ram_data;

    assign ram_cnt   = wptr - rptr;
    assign ram_full  = (ram_cnt == 7'd64);
    assign ram_empty = (wptr == rptr);

    // run keeps in_ready low while in reset and for the cycle in which reset is released.
    assign in_ready = run && !ram_full && !flush;
    assign wr       = in_valid && in_ready;
    assign load     = !ram_empty && (!out_valid || out_ready);

    ram64xsdp #(.WIDTH(WIDTH)) u_ram (
        .wclk  (clk),
        .we    (wr),
        .waddr (wptr[5:0]),
        .datai (in_data),
        .raddr (rptr[5:0]),
        .datao (ram_data)
    );

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        wptr_nxt      = wptr;
        rptr_nxt      = rptr;
        out_valid_nxt = out_valid;
        if (flush) begin
            wptr_nxt      = '0;
            rptr_nxt      = '0;
            out_valid_nxt = 1'b0;
        end else begin
            if (wr) wptr_nxt = wptr + 7'd1;
            if (load) begin
                rptr_nxt      = rptr + 7'd1;
                out_valid_nxt = 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid_nxt = 1'b0;
            end
        end
        level_nxt = (wptr_nxt - rptr_nxt) + {6'd0, out_valid_nxt};
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            level     <= '0;
        end else begin
            run       <= 1'b1;
            wptr      <= wptr_nxt;
            rptr      <= rptr_nxt;
            out_valid <= out_valid_nxt;
            level     <= level_nxt;
            if (load && !flush) out_data <= ram_data;
        end
    end

`ifdef FIFO64_ALMOST_EN
    localparam logic [6:0] AFULL_LVL  = 7'(AFULL_THRESH);
    localparam logic [6:0] AEMPTY_LVL = 7'(AEMPTY_THRESH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (level_nxt >= AFULL_LVL);
            almost_empty <= (level_nxt <= AEMPTY_LVL);
        end
    end
`endif
endmodule

// File: tb/tb_fifo64_fwft.sv
// Randomized self-checking bench for fifo64_fwft against a two-stage queue model
// (RAM queue plus one output slot). Almost-flag checks compile in with FIFO64_ALMOST_EN.

module tb_fifo64_fwft;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [6:0]   level;
`ifdef FIFO64_ALMOST_EN
    logic         almost_full;
    logic         almost_empty;
`endif

    fifo64_fwft #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .level        (level)
`ifdef FIFO64_ALMOST_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: words waiting in RAM, plus the single output slot.
    logic [W-1:0] ram_q[$];
    logic [W-1:0] out_log[$];
    bit           m_ov;
    logic [W-1:0] m_od;
    bit           m_run;

    function automatic int m_level();
        return ram_q.size() + int'(m_ov);
    endfunction

    task automatic model_reset();
        ram_q.delete();
        m_ov  = 1'b0;
        m_od  = '0;
        m_run = 1'b0;
    endtask

    // One clock cycle: check in_ready before the edge, advance model, check outputs after.
    task automatic step();
        bit exp_ready, acc, ld, fire;
        int exp_level;
        #1;
        exp_ready = m_run && !flush && (ram_q.size() < 64);
        checks++;
        if (in_ready !== exp_ready) begin
            errors++;
            $display("FAIL step_in_ready t=%0t: got %b expected %b", $time, in_ready, exp_ready);
        end
        acc  = in_valid && exp_ready;
        fire = m_ov && out_ready;
        ld   = (ram_q.size() > 0) && (!m_ov || out_ready);
        if (fire && !flush) out_log.push_back(m_od);
        @(posedge clk);
        if (flush) begin
            ram_q.delete();
            m_ov = 1'b0;
        end else begin
            if (ld) begin
                m_od = ram_q.pop_front();
                m_ov = 1'b1;
            end else if (fire) begin
                m_ov = 1'b0;
            end
            if (acc) ram_q.push_back(in_data);
        end
        m_run = 1'b1;
        #1;
        exp_level = m_level();
        checks++;
        if (out_valid !== m_ov) begin
            errors++;
            $display("FAIL step_out_valid t=%0t: got %b expected %b", $time, out_valid, m_ov);
        end
        checks++;
        if (level !== 7'(exp_level)) begin
            errors++;
            $display("FAIL step_level t=%0t: got %0d expected %0d", $time, level, exp_level);
        end
        checks++;
        if (out_data !== m_od) begin
            errors++;
            $display("FAIL step_out_data t=%0t: got %h expected %h", $time, out_data, m_od);
        end
`ifdef FIFO64_ALMOST_EN
        checks++;
        if (almost_full !== (exp_level >= 48) || almost_empty !== (exp_level <= 8)) begin
            errors++;
            $display("FAIL step_almost t=%0t: got af=%b ae=%b expected af=%b ae=%b", $time,
                     almost_full, almost_empty, exp_level >= 48, exp_level <= 8);
        end
`endif
    endtask

    task automatic drain(input int cycles);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || level !== 7'd0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b ov=%b lvl=%0d od=%h expected 0 0 0 0",
                     in_ready, out_valid, level, out_data);
        end
`ifdef FIFO64_ALMOST_EN
        checks++;
        if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_almost: got af=%b ae=%b expected 0 1", almost_full, almost_empty);
        end
`endif
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_single();
        in_valid = 1'b1;
        in_data  = 16'h1234;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || level !== 7'd1) begin
            errors++;
            $display("FAIL single_write_edge: got ov=%b lvl=%0d expected 0 1", out_valid, level);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h1234 || level !== 7'd1) begin
            errors++;
            $display("FAIL single_fallthrough: got ov=%b od=%h lvl=%0d expected 1 1234 1",
                     out_valid, out_data, level);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || level !== 7'd0) begin
            errors++;
            $display("FAIL single_pop: got ov=%b lvl=%0d expected 0 0", out_valid, level);
        end
    endtask

    task automatic test_fill();
        int acc = 0;
        bit ok  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 70; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(acc);
            #1;
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (acc != 65 || level !== 7'd65 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_capacity: got acc=%0d lvl=%0d rdy=%b expected 65 65 0", acc, level, in_ready);
        end
        out_log.delete();
        drain(70);
        if (out_log.size() != 65) ok = 1'b0;
        for (int i = 0; i < out_log.size() && i < 65; i++)
            if (out_log[i] !== 16'(i)) ok = 1'b0;
        checks++;
        if (!ok || level !== 7'd0) begin
            errors++;
            $display("FAIL fill_drain_order: got n=%0d lvl=%0d expected 65 words 0..64 lvl 0",
                     out_log.size(), level);
        end
    endtask

    task automatic test_stream();
        logic [W-1:0] sent[$];
        bit ok = 1'b1;
        out_log.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 202; i++) begin
            in_valid = (i < 200);
            in_data  = 16'($urandom());
            if (i < 200) sent.push_back(in_data);
            step();
        end
        in_valid = 1'b0;
        if (out_log.size() != 200) ok = 1'b0;
        for (int i = 0; i < out_log.size() && i < 200; i++)
            if (out_log[i] !== sent[i]) ok = 1'b0;
        checks++;
        if (!ok || level !== 7'd0) begin
            errors++;
            $display("FAIL stream_throughput: got n=%0d lvl=%0d expected 200 intact words lvl 0",
                     out_log.size(), level);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full_both();
        int next = 0;
        bit ok   = 1'b1;
        bit lvl_ok = 1'b1;
        out_log.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 65; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(next + 16'h0100);
            next++;
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_data = 16'(next + 16'h0100);
            #1;
            if (in_ready) next++;
            step();
            if (level < 7'd64 || level > 7'd65) lvl_ok = 1'b0;
        end
        drain(70);
        if (out_log.size() != next) ok = 1'b0;
        for (int i = 0; i < out_log.size(); i++)
            if (out_log[i] !== 16'(i + 16'h0100)) ok = 1'b0;
        checks++;
        if (!ok || !lvl_ok) begin
            errors++;
            $display("FAIL full_both: got n=%0d order_ok=%b lvl_ok=%b expected n=%0d 1 1",
                     out_log.size(), ok, lvl_ok, next);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom());
            step();
        end
        checks++;
        if (level !== 7'd30) begin
            errors++;
            $display("FAIL flush_pre_level: got %0d expected 30", level);
        end
        flush    = 1'b1;
        in_data  = 16'hDEAD;
        step();
        flush    = 1'b0;
        checks++;
        if (level !== 7'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: got lvl=%0d ov=%b expected 0 0", level, out_valid);
        end
        in_data = 16'hBEEF;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hBEEF || level !== 7'd1) begin
            errors++;
            $display("FAIL flush_next_word: got ov=%b od=%h lvl=%0d expected 1 beef 1",
                     out_valid, out_data, level);
        end
        drain(3);
    endtask

`ifdef FIFO64_ALMOST_EN
    task automatic test_almost();
        out_ready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom());
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (almost_full !== 1'b1 || almost_empty !== 1'b0) begin
            errors++;
            $display("FAIL almost_high: got af=%b ae=%b expected 1 0", almost_full, almost_empty);
        end
        drain(60);
        checks++;
        if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin
            errors++;
            $display("FAIL almost_low: got af=%b ae=%b expected 0 1", almost_full, almost_empty);
        end
    endtask
`endif

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom());
            step();
        end
        checks++;
        if (level !== 7'd10) begin
            errors++;
            $display("FAIL areset_pre_level: got %0d expected 10", level);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || level !== 7'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: got ov=%b lvl=%0d rdy=%b expected 0 0 0",
                     out_valid, level, in_ready);
        end
`ifdef FIFO64_ALMOST_EN
        checks++;
        if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin
            errors++;
            $display("FAIL areset_almost: got af=%b ae=%b expected 0 1", almost_full, almost_empty);
        end
`endif
        model_reset();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_random();
        int rdy_pct = 70;
        out_log.delete();
        for (int i = 0; i < 1500; i++) begin
            if (i % 200 == 0) rdy_pct = int'($urandom_range(10, 95));
            in_valid  = ($urandom_range(0, 99) < 75);
            out_ready = (int'($urandom_range(0, 99)) < rdy_pct);
            flush     = ($urandom_range(0, 199) == 0);
            in_data   = 16'($urandom());
            step();
        end
        flush = 1'b0;
        drain(70);
        checks++;
        if (level !== 7'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_final_empty: got lvl=%0d ov=%b expected 0 0", level, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_full_both();
        test_flush();
`ifdef FIFO64_ALMOST_EN
        test_almost();
`endif
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
